beehive_noc_msg_deframer: RTL and testbench

//  Receive-side counterpart to the Beehive NoC header packers. Accepts one NoC flit

---
 rtl/beehive_noc_msg_deframer.sv | 152 +++++++++++++++
 tb/tb_beehive_noc_msg_deframer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beehive_noc_msg_deframer.sv
// Splits one NoC flit stream into header, metadata and data streams using msg_len/metadata_flits.
// Optional BEEHIVE_NOC_DEFRAMER_STATS_EN adds saturating message/flit/length-error counters.
module beehive_noc_msg_deframer #(
  parameter int NOC_DATA_W = 512,
  parameter int LEN_W      = 22,
  parameter int META_W     = 8,
  // header field positions (dst_x/dst_y/dst_fbits above msg_len; type + src fields above metadata_flits)
  parameter int LEN_LSB    = NOC_DATA_W - 20 - LEN_W,
  parameter int META_LSB   = LEN_LSB - 28 - META_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_noc_in_val,
  input  logic [NOC_DATA_W-1:0] i_noc_in_data,
  output logic                  o_noc_in_rdy,
  output logic                  o_hdr_val,
  output logic [NOC_DATA_W-1:0] o_hdr_data,
  output logic                  o_hdr_len_err,
  input  logic                  i_hdr_rdy,
  output logic                  o_meta_val,
  output logic [NOC_DATA_W-1:0] o_meta_data,
  output logic                  o_meta_last,
  input  logic                  i_meta_rdy,
  output logic                  o_data_val,
  output logic [NOC_DATA_W-1:0] o_data_data,
  output logic                  o_data_last,
  input  logic                  i_data_rdy
`ifdef BEEHIVE_NOC_DEFRAMER_STATS_EN
  ,
  output logic [31:0]           o_stat_msgs,
  output logic [31:0]           o_stat_flits,
  output logic [15:0]           o_stat_len_errs
`endif
);

  // state   | meaning
  // HDR_RX  | waiting for a header flit
  // HDR_OUT | header held on hdr_*, input stalled
  // META    | passing metadata flits through
  // DATA    | passing data flits through
  typedef enum logic [1:0] {HDR_RX, HDR_OUT, META, DATA} state_t;

  localparam int CW = (LEN_W > META_W) ? LEN_W : META_W;

  state_t                r_state;
  logic [NOC_DATA_W-1:0] r_hdr_data;
  logic                  r_err;
  logic [LEN_W-1:0]      r_rem;
  logic [LEN_W-1:0]      r_mrem;

  logic [CW-1:0]         w_len_ext;
  logic [CW-1:0]         w_meta_ext;
  logic                  w_len_err;
  logic [LEN_W-1:0]      w_len;
  logic [LEN_W-1:0]      w_mrem_init;
  logic                  w_in_hs;
  logic                  w_hdr_hs;

  assign w_len       = i_noc_in_data[LEN_LSB +: LEN_W];
  assign w_len_ext   = CW'(i_noc_in_data[LEN_LSB +: LEN_W]);
  assign w_meta_ext  = CW'(i_noc_in_data[META_LSB +: META_W]);
  assign w_len_err   = (w_meta_ext > w_len_ext);
  // an oversized metadata count is clamped so every body flit lands in META
  assign w_mrem_init = w_len_err ? w_len : LEN_W'(w_meta_ext);

  assign o_noc_in_rdy = rst_n & ((r_state == HDR_RX) |
                                 ((r_state == META) & i_meta_rdy) |
                                 ((r_state == DATA) & i_data_rdy));
  assign w_in_hs      = i_noc_in_val & o_noc_in_rdy;

  assign o_hdr_val     = (r_state == HDR_OUT);
  assign o_hdr_data    = r_hdr_data;
  assign o_hdr_len_err = o_hdr_val & r_err;
  assign w_hdr_hs      = o_hdr_val & i_hdr_rdy;

  assign o_meta_val  = (r_state == META) & i_noc_in_val;
  assign o_meta_data = i_noc_in_data;
  assign o_meta_last = (r_state == META) & (r_mrem == LEN_W'(1));
  assign o_data_val  = (r_state == DATA) & i_noc_in_val;
  assign o_data_data = i_noc_in_data;
  assign o_data_last = (r_state == DATA) & (r_rem == LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HDR_RX;
      r_hdr_data <= '0;
      r_err      <= 1'b0;
      r_rem      <= '0;
      r_mrem     <= '0;
    end else begin
      case (r_state)
        HDR_RX: begin
          if (i_noc_in_val) begin
            r_hdr_data <= i_noc_in_data;
            r_rem      <= w_len;
            r_mrem     <= w_mrem_init;
            r_err      <= w_len_err;
            r_state    <= HDR_OUT;
          end
        end
        HDR_OUT: begin
          if (i_hdr_rdy) begin
            if (r_mrem != '0)     r_state <= META;
            else if (r_rem != '0) r_state <= DATA;
            else                  r_state <= HDR_RX;
          end
        end
        META: begin
          if (i_noc_in_val && i_meta_rdy) begin
            r_mrem <= r_mrem - LEN_W'(1);
            r_rem  <= r_rem - LEN_W'(1);
            if (r_mrem == LEN_W'(1))
              r_state <= (r_rem > LEN_W'(1)) ? DATA : HDR_RX;
          end
        end
        DATA: begin
          if (i_noc_in_val && i_data_rdy) begin
            r_rem <= r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1)) r_state <= HDR_RX;
          end
        end
        default: r_state <= HDR_RX;
      endcase
    end
  end

`ifdef BEEHIVE_NOC_DEFRAMER_STATS_EN
  logic [31:0] r_stat_msgs;
  logic [31:0] r_stat_flits;
  logic [15:0] r_stat_len_errs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_msgs     <= '0;
      r_stat_flits    <= '0;
      r_stat_len_errs <= '0;
    end else begin
      if (w_hdr_hs && (r_stat_msgs != '1))
        r_stat_msgs <= r_stat_msgs + 32'd1;
      if (w_hdr_hs && r_err && (r_stat_len_errs != '1))
        r_stat_len_errs <= r_stat_len_errs + 16'd1;
      if (w_in_hs && (r_stat_flits != '1))
        r_stat_flits <= r_stat_flits + 32'd1;
    end
  end

  assign o_stat_msgs     = r_stat_msgs;
  assign o_stat_flits    = r_stat_flits;
  assign o_stat_len_errs = r_stat_len_errs;
`endif

endmodule

// File: tb/tb_beehive_noc_msg_deframer.sv
// Directed self-checking bench for beehive_noc_msg_deframer (64-bit flits, 4-bit msg_len).
module tb_beehive_noc_msg_deframer;

  localparam int DW       = 64;
  localparam int LW       = 4;
  localparam int MW       = 8;
  localparam int LEN_LSB  = 40;
  localparam int META_LSB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_val;
  logic [DW-1:0] in_data;
  logic          in_rdy;
  logic          hdr_val;
  logic [DW-1:0] hdr_data;
  logic          hdr_len_err;
  logic          hdr_rdy;
  logic          meta_val;
  logic [DW-1:0] meta_data;
  logic          meta_last;
  logic          meta_rdy;
  logic          data_val;
  logic [DW-1:0] data_data;
  logic          data_last;
  logic          data_rdy;
`ifdef BEEHIVE_NOC_DEFRAMER_STATS_EN
  logic [31:0]   stat_msgs;
  logic [31:0]   stat_flits;
  logic [15:0]   stat_len_errs;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  beehive_noc_msg_deframer #(
    .NOC_DATA_W(DW), .LEN_W(LW), .META_W(MW), .LEN_LSB(LEN_LSB), .META_LSB(META_LSB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_noc_in_val(in_val), .i_noc_in_data(in_data), .o_noc_in_rdy(in_rdy),
    .o_hdr_val(hdr_val), .o_hdr_data(hdr_data), .o_hdr_len_err(hdr_len_err), .i_hdr_rdy(hdr_rdy),
    .o_meta_val(meta_val), .o_meta_data(meta_data), .o_meta_last(meta_last), .i_meta_rdy(meta_rdy),
    .o_data_val(data_val), .o_data_data(data_data), .o_data_last(data_last), .i_data_rdy(data_rdy)
`ifdef BEEHIVE_NOC_DEFRAMER_STATS_EN
    , .o_stat_msgs(stat_msgs), .o_stat_flits(stat_flits), .o_stat_len_errs(stat_len_errs)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_hdr(input int len, input int meta, input logic [15:0] tag);
    logic [DW-1:0] h;
    h = '0;
    h[63:48] = tag;
    h[LEN_LSB +: LW]   = len[LW-1:0];
    h[META_LSB +: MW]  = meta[MW-1:0];
    return h;
  endfunction

  function automatic logic [DW-1:0] body(input logic [15:0] tag, input int i);
    return {tag, 48'(i)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    logic [DW-1:0] h;

    rst_n = 1'b0; in_val = 1'b0; in_data = '0;
    hdr_rdy = 1'b0; meta_rdy = 1'b0; data_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // reset: outputs quiet even with a valid flit presented
    in_val = 1'b1; in_data = mk_hdr(3, 1, 16'h1111);
    hdr_rdy = 1'b1; meta_rdy = 1'b1; data_rdy = 1'b1;
    #1;
    chk1("rst_in_rdy", in_rdy, 1'b0);
    chk1("rst_hdr_val", hdr_val, 1'b0);
    chk1("rst_hdr_err", hdr_len_err, 1'b0);
    chk1("rst_meta_val", meta_val, 1'b0);
    chk1("rst_meta_last", meta_last, 1'b0);
    chk1("rst_data_val", data_val, 1'b0);
    chk1("rst_data_last", data_last, 1'b0);
`ifdef BEEHIVE_NOC_DEFRAMER_STATS_EN
    chkw("rst_stat_msgs", 64'(stat_msgs), 64'd0);
    chkw("rst_stat_flits", 64'(stat_flits), 64'd0);
`endif
    @(negedge clk); rst_n = 1'b1; in_val = 1'b0; #1;
    chk1("idle_in_rdy", in_rdy, 1'b1);

    // case 1: msg_len=3, metadata_flits=1
    h = mk_hdr(3, 1, 16'h1111);
    @(negedge clk); in_val = 1'b1; in_data = h; #1;
    chk1("c1_accept_rdy", in_rdy, 1'b1);
    chk1("c1_hdr_not_yet", hdr_val, 1'b0);
    @(negedge clk); in_data = body(16'hAE7A, 0); #1;
    chk1("c1_hdr_val", hdr_val, 1'b1);
    chkw("c1_hdr_data", hdr_data, h);
    chk1("c1_hdr_err", hdr_len_err, 1'b0);
    chk1("c1_hdrout_in_rdy", in_rdy, 1'b0);
    chk1("c1_hdrout_meta_val", meta_val, 1'b0);
    @(negedge clk); #1;
    chk1("c1_meta_val", meta_val, 1'b1);
    chkw("c1_meta_data", meta_data, body(16'hAE7A, 0));
    chk1("c1_meta_last", meta_last, 1'b1);
    chk1("c1_meta_no_data", data_val, 1'b0);
    chk1("c1_meta_hdr_low", hdr_val, 1'b0);
    @(negedge clk); in_data = body(16'hDA7A, 0); #1;
    chk1("c1_d0_val", data_val, 1'b1);
    chkw("c1_d0_data", data_data, body(16'hDA7A, 0));
    chk1("c1_d0_last", data_last, 1'b0);
    chk1("c1_d0_no_meta", meta_val, 1'b0);
    @(negedge clk); in_data = body(16'hDA7A, 1); #1;
    chkw("c1_d1_data", data_data, body(16'hDA7A, 1));
    chk1("c1_d1_last", data_last, 1'b1);
    @(negedge clk); in_val = 1'b0; #1;
    chk1("c1_end_in_rdy", in_rdy, 1'b1);
    chk1("c1_end_data_val", data_val, 1'b0);

    // case 3: metadata_flits=6 > msg_len=4
    h = mk_hdr(4, 6, 16'h3333);
    @(negedge clk); in_val = 1'b1; in_data = h; #1;
    chk1("c3_accept_rdy", in_rdy, 1'b1);
    @(negedge clk); in_data = body(16'hAE7A, 0); #1;
    chk1("c3_hdr_val", hdr_val, 1'b1);
    chk1("c3_hdr_err", hdr_len_err, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_data = body(16'hAE7A, i); #1;
      chk1("c3_meta_val", meta_val, 1'b1);
      chkw("c3_meta_data", meta_data, body(16'hAE7A, i));
      chk1("c3_meta_last", meta_last, (i == 3));
      chk1("c3_no_data", data_val, 1'b0);
    end
    @(negedge clk); in_val = 1'b0; #1;
    chk1("c3_end_in_rdy", in_rdy, 1'b1);
    chk1("c3_end_meta_val", meta_val, 1'b0);
    chk1("c3_end_hdr_val", hdr_val, 1'b0);
`ifdef BEEHIVE_NOC_DEFRAMER_STATS_EN
    chkw("c6_stat_msgs", 64'(stat_msgs), 64'd2);
    chkw("c6_stat_flits", 64'(stat_flits), 64'd9);
    chkw("c6_stat_len_errs", 64'(stat_len_errs), 64'd1);
`endif

    // case 2: two zero-length messages back-to-back
    @(negedge clk); in_val = 1'b1; in_data = mk_hdr(0, 0, 16'h2A2A); #1;
    chk1("c2_a_rdy", in_rdy, 1'b1);
    @(negedge clk); in_data = mk_hdr(0, 0, 16'h2B2B); #1;
    chk1("c2_a_hdr_val", hdr_val, 1'b1);
    chkw("c2_a_hdr_data", hdr_data, mk_hdr(0, 0, 16'h2A2A));
    chk1("c2_a_in_rdy_low", in_rdy, 1'b0);
    chk1("c2_a_meta_val", meta_val, 1'b0);
    chk1("c2_a_data_val", data_val, 1'b0);
    @(negedge clk); #1;
    chk1("c2_gap_hdr_val", hdr_val, 1'b0);
    chk1("c2_b_rdy", in_rdy, 1'b1);
    @(negedge clk); in_val = 1'b0; #1;
    chk1("c2_b_hdr_val", hdr_val, 1'b1);
    chkw("c2_b_hdr_data", hdr_data, mk_hdr(0, 0, 16'h2B2B));
    chk1("c2_b_in_rdy_low", in_rdy, 1'b0);
    @(negedge clk); #1;
    chk1("c2_end_hdr_val", hdr_val, 1'b0);
    chk1("c2_end_data_val", data_val, 1'b0);

    // case 4: msg_len=5, no metadata, stalled header, gapped input, random sink stalls
    @(negedge clk); in_val = 1'b1; in_data = mk_hdr(5, 0, 16'h4444); hdr_rdy = 1'b0; #1;
    @(negedge clk); in_val = 1'b0; #1;
    chk1("c4_hdr_val", hdr_val, 1'b1);
    @(negedge clk); hdr_rdy = 1'b1; #1;
    chk1("c4_hdr_held", hdr_val, 1'b1);
    chk1("c4_hdr_in_rdy", in_rdy, 1'b0);
    idx = 0; cyc = 0;
    while (idx < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      in_val   = 1'($urandom_range(0, 1));
      data_rdy = 1'($urandom_range(0, 1));
      in_data  = body(16'hDA7A, idx);
      #1;
      chk1("c4_data_val", data_val, in_val);
      chk1("c4_in_rdy", in_rdy, data_rdy);
      chk1("c4_data_last", data_last, (idx == 4));
      chk1("c4_no_meta", meta_val, 1'b0);
      if (in_val && data_rdy) begin
        chkw("c4_data_data", data_data, body(16'hDA7A, idx));
        idx++;
      end
    end
    chkw("c4_flits_done", 64'(idx), 64'd5);
    @(negedge clk); in_val = 1'b0; data_rdy = 1'b1; #1;
    chk1("c4_end_data_val", data_val, 1'b0);
    chk1("c4_end_in_rdy", in_rdy, 1'b1);

    // maximum msg_len (15) with 2 metadata flits: counters must not wrap
    h = mk_hdr(15, 2, 16'h5555);
    @(negedge clk); in_val = 1'b1; in_data = h; #1;
    @(negedge clk); #1;
    chk1("max_hdr_val", hdr_val, 1'b1);
    chk1("max_hdr_err", hdr_len_err, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); in_data = body(16'hB0D1, i); #1;
      if (i < 2) begin
        chk1("max_meta_val", meta_val, 1'b1);
        chk1("max_meta_last", meta_last, (i == 1));
        chk1("max_meta_no_data", data_val, 1'b0);
      end else begin
        chk1("max_data_val", data_val, 1'b1);
        chkw("max_data_data", data_data, body(16'hB0D1, i));
        chk1("max_data_last", data_last, (i == 14));
        chk1("max_data_no_meta", meta_val, 1'b0);
      end
    end
    @(negedge clk); in_val = 1'b0; #1;
    chk1("max_end_in_rdy", in_rdy, 1'b1);
    chk1("max_end_data_val", data_val, 1'b0);

    // metadata_flits=16 exceeds msg_len=1 only when compared at full width
    @(negedge clk); in_val = 1'b1; in_data = mk_hdr(1, 16, 16'h6666); #1;
    @(negedge clk); in_data = body(16'hAE7A, 9); #1;
    chk1("wide_hdr_err", hdr_len_err, 1'b1);
    @(negedge clk); #1;
    chk1("wide_meta_val", meta_val, 1'b1);
    chk1("wide_meta_last", meta_last, 1'b1);
    @(negedge clk); in_val = 1'b0; #1;
    chk1("wide_end_in_rdy", in_rdy, 1'b1);
    chk1("wide_end_data_val", data_val, 1'b0);

    // case 5: reset after 2 of 5 data flits
    @(negedge clk); in_val = 1'b1; in_data = mk_hdr(5, 0, 16'h7777); #1;
    @(negedge clk); in_data = body(16'hDA7A, 0); #1;
    chk1("c5_hdr_val", hdr_val, 1'b1);
    @(negedge clk); #1;
    chk1("c5_d0_val", data_val, 1'b1);
    @(negedge clk); in_data = body(16'hDA7A, 1); #1;
    chk1("c5_d1_val", data_val, 1'b1);
    @(negedge clk); in_data = body(16'hDA7A, 2); rst_n = 1'b0; #1;
    chk1("c5_rst_in_rdy", in_rdy, 1'b0);
    chk1("c5_rst_data_val", data_val, 1'b0);
    chk1("c5_rst_data_last", data_last, 1'b0);
    chk1("c5_rst_hdr_val", hdr_val, 1'b0);
`ifdef BEEHIVE_NOC_DEFRAMER_STATS_EN
    chkw("c5_rst_stat_msgs", 64'(stat_msgs), 64'd0);
`endif
    h = mk_hdr(1, 1, 16'h8888);
    @(negedge clk); rst_n = 1'b1; in_data = h; #1;
    chk1("c5_post_rdy", in_rdy, 1'b1);
    @(negedge clk); in_data = body(16'hAE7A, 0); #1;
    chk1("c5_post_hdr_val", hdr_val, 1'b1);
    chkw("c5_post_hdr_data", hdr_data, h);
    @(negedge clk); #1;
    chk1("c5_post_meta_val", meta_val, 1'b1);
    chk1("c5_post_meta_last", meta_last, 1'b1);
    @(negedge clk); in_val = 1'b0; #1;
    chk1("c5_end_in_rdy", in_rdy, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
